// File: rtl/gated_elastic_pipe.sv
// Multi-channel elastic valid/ready register pipeline with per-channel data gating,
// flush, and a registered per-channel occupancy count.
module gated_elastic_pipe #(
  parameter int              WIDTH       = 1,
  parameter int              CHANNELS    = 1,
  parameter int              DEPTH       = 2,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [CHANNELS-1:0]                 gate,
  input  logic [CHANNELS-1:0]                 in_valid,
  output logic [CHANNELS-1:0]                 in_ready,
  input  logic [CHANNELS*WIDTH-1:0]           in_data,
  output logic [CHANNELS-1:0]                 out_valid,
  input  logic [CHANNELS-1:0]                 out_ready,
  output logic [CHANNELS*WIDTH-1:0]           out_data,
  output logic [CHANNELS*$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_nxt;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] d_q   [DEPTH];
    logic [WIDTH-1:0] d_nxt [DEPTH];
    logic [OW-1:0]    occ_q;
    logic [OW-1:0]    occ_nxt;
    logic             ov;
    logic             ir;
    logic             in_xfer;

    assign ov      = v_q[DEPTH-1] & ~flush;
    assign ir      = ~flush & ~rst & load[0];
    assign in_xfer = in_valid[c] & ir;

    // A stage may load when empty or when the stage ahead of it is loading,
    // so ready ripples back through the whole chain without bubbles.
    always_comb begin
      load = '0;
      load[DEPTH-1] = ~v_q[DEPTH-1] | (ov & out_ready[c]);
      for (int s = DEPTH-2; s >= 0; s--) begin
        load[s] = ~v_q[s] | load[s+1];
      end
    end

    always_comb begin
      v_nxt   = v_q;
      d_nxt   = d_q;
      occ_nxt = '0;
      if (load[0]) begin
        v_nxt[0] = in_xfer;
        d_nxt[0] = (in_xfer && gate[c]) ? in_data[c*WIDTH +: WIDTH] : CLEAR_VALUE;
      end
      for (int s = 1; s < DEPTH; s++) begin
        if (load[s]) begin
          v_nxt[s] = v_q[s-1];
          d_nxt[s] = d_q[s-1];
        end
      end
      for (int s = 0; s < DEPTH; s++) begin
        occ_nxt = occ_nxt + OW'(v_nxt[s]);
      end
    end

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        v_q   <= '0;
        occ_q <= '0;
        for (int s = 0; s < DEPTH; s++) begin
          d_q[s] <= CLEAR_VALUE;
        end
      end else begin
        v_q   <= v_nxt;
        d_q   <= d_nxt;
        occ_q <= occ_nxt;
      end
    end

    // Empty stages already hold CLEAR_VALUE; the mux also covers the flush cycle.
    assign out_valid[c]                = ov;
    assign out_data[c*WIDTH +: WIDTH]  = ov ? d_q[DEPTH-1] : CLEAR_VALUE;
    assign in_ready[c]                 = ir;
    assign occupancy[c*OW +: OW]       = occ_q;
  end

endmodule
